video_dma_scheduler: RTL and testbench
======================================

// Module: video_dma_scheduler
// PURPOSE
//  Shares the single nasti_data_mover of the display path between two requesters: port L (scanline
//  prefetch, strict priority) and port A (auxiliary fetches: cursor/overlay/palette). Splits each
//  request into chunks of at most CHUNK_BYTES and sequences the mover's level en / done protocol.
//  Flags scanline underrun against a per-line deadline. Sits in the aclk domain between the pixel-side
//  descriptor synchroniser and the data mover.
// PARAMETERS
//  ADDR_WIDTH   64   width of source/destination addresses and mover length
//  LEN_WIDTH    16   width of request length, in bytes
//  CHUNK_BYTES  512  maximum bytes per mover transaction; power of two, >= 8
// PORTS
//  aclk               in   1           clock
//  aresetn            in   1           asynchronous active-low reset
//  enable_i           in   1           scheduler enable
//  l_req_valid_i      in   1           port L request valid
//  l_req_ready_o      out  1           port L can accept; handshake = valid & ready
//  l_src_i / l_dest_i in   ADDR_WIDTH  port L source / destination byte address (8-byte aligned)
//  l_len_i            in   LEN_WIDTH   port L length in bytes; bits [2:0] ignored (forced 0)
//  l_done_o           out  1           one-cycle pulse when the last port L chunk completes
//  a_req_valid_i, a_req_ready_o, a_src_i, a_dest_i, a_len_i, a_done_o: same as port L, for port A
//  l_deadline_i       in   1           one-cycle pulse: port L data is needed now
//  underrun_o         out  1           sticky: deadline hit while a port L request was outstanding
//  underrun_clr_i     in   1           clears underrun_o
//  mover_src_addr_o   out  ADDR_WIDTH  data mover source address
//  mover_dest_addr_o  out  ADDR_WIDTH  data mover destination address
//  mover_length_o     out  ADDR_WIDTH  data mover length, in bytes
//  mover_en_o         out  1           data mover enable (level)
//  mover_done_i       in   1           data mover done (level)
//  busy_o             out  1           FSM not IDLE, or any context active
//  stat_l_cnt_o, stat_a_cnt_o, stat_urun_cnt_o  out 32  statistics counters (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: every output 0, except ready outputs, which follow enable_i. FSM in IDLE; both contexts inactive.
//  - Contexts: one per port {active, src, dest, remaining}.
//  - Ready and accept:
//    - x_req_ready_o = enable_i & !ctx_x.active.
//    - On handshake the context loads with remaining = len & ~7.
//    - remaining == 0: context stays inactive; x_done_o pulses on the next cycle; the mover is not used.
//  - FSM IDLE:
//    - Picks L if its context is active, else A.
//    - Registers src, dest and chunk = min(remaining, CHUNK_BYTES), then goes to ISSUE.
//    - mover_en_o rises no earlier than 1 cycle after accept.
//  - FSM ISSUE:
//    - mover_en_o = 1; descriptor outputs are held stable.
//    - On mover_done_i = 1: src += chunk, dest += chunk, remaining -= chunk (all modulo 2^width).
//    - If remaining reaches 0: context cleared and x_done_o pulses on the same edge. Go to DRAIN.
//  - FSM DRAIN:
//    - mover_en_o = 0; wait for mover_done_i = 0, then go to IDLE.
//    - mover_done_i already high when DRAIN is entered: stay in DRAIN until it falls.
//  - Preemption: arbitration happens only in IDLE, so port L preempts port A at chunk boundaries.
//    Port A resumes from its saved context afterwards. A chunk in flight is never aborted.
//  - Underrun:
//    - Set: l_deadline_i while ctx_L.active, excluding the cycle in which ctx_L's last chunk completes.
//    - Clear: underrun_clr_i, but a set in the same cycle wins.
//  - enable_i low:
//    - No new accepts.
//    - A chunk in ISSUE finishes normally, then both contexts are discarded without any done pulse.
//    - FSM returns to IDLE via DRAIN.
//  - aresetn asserted mid-transfer: immediate return to the reset state. The mover shares the same reset.
// CONFIGURATION
//  - VIDEO_DMA_SCHED_STATS_EN defined:
//    - stat_l_cnt_o: +1 per l_done_o.
//    - stat_a_cnt_o: +1 per a_done_o.
//    - stat_urun_cnt_o: +1 per underrun set event.
//    - All three are 32-bit wrapping counters, cleared by reset only.
//  - Not defined: the stat outputs are tied to 0 and no counter flops are built.
// STRUCTURE
//  - video_dma_pkg: sched_state_e {IDLE, ISSUE, DRAIN}; req_id_e {REQ_L, REQ_A}; dma_desc_t {src, dest, len}.
//  - Sub-module video_dma_ctx (instanced twice): context register, accept logic, chunk min/advance arithmetic.
// TESTING
//  - Single L request: src=0x1000, len=1280 -> 3 chunks (512, 512, 256) at 0x1000/0x1200/0x1400;
//    l_done_o pulses once; the mover sees en low between chunks.
//  - Preemption: A accepted with len=2048; after A's first chunk, L arrives with len=256 ->
//    mover order A512, L256, A512 x3; A resumes at src+512.
//  - Zero length: l_len_i=5 -> treated as 0; l_done_o pulses the cycle after accept; mover_en_o stays 0.
//  - Underrun: L with len=4096 and l_deadline_i mid-transfer -> underrun_o=1 and stat_urun_cnt_o=1 (STATS_EN);
//    clr and deadline in the same cycle -> remains 1.
//  - Disable mid-transfer: enable_i low during ISSUE of chunk 2 of 4 -> chunk 2 completes, no done pulse,
//    busy_o=0 after DRAIN; both ready outputs stay 0 until re-enable.
//  - Reset mid-ISSUE: aresetn low -> mover_en_o=0, all done outputs=0 and all stat outputs=0 asynchronously.

Source files
------------

// File: rtl/video_dma_pkg.sv
`default_nettype none
// ============================================================================
// Module      : video_dma_pkg
// Description : Shared types for the display-path DMA scheduler: FSM state,
//               requester identifiers, the mover descriptor record and a small
//               arithmetic helper used for chunk sizing.
// Revision    : 1.0 - initial release
// ============================================================================
package video_dma_pkg;

  // Widest address the descriptor record can carry; ADDR_WIDTH must not exceed it.
  localparam int unsigned MAX_ADDR_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } sched_state_e;

  typedef enum logic {
    REQ_L = 1'b0,
    REQ_A = 1'b1
  } req_id_e;

  typedef struct packed {
    logic [MAX_ADDR_WIDTH-1:0] src;
    logic [MAX_ADDR_WIDTH-1:0] dest;
    logic [MAX_ADDR_WIDTH-1:0] len;
  } dma_desc_t;

  function automatic logic [31:0] min_u32(input logic [31:0] a, input logic [31:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/video_dma_ctx.sv
`default_nettype none
// ============================================================================
// Module      : video_dma_ctx
// Description : One requester context {active, src, dest, remaining}. Handles
//               the valid/ready accept, offers the next chunk size and
//               advances the context when the scheduler reports a finished
//               chunk. Emits a one-cycle done pulse when the request ends
//               (last chunk finished, or a zero-length request accepted).
// Ports       : clk, rst_n (async, active low)
//               i_enable, i_req_valid, o_req_ready, i_src, i_dest, i_len
//               i_advance  - current chunk of this context completed
//               i_discard  - drop the context without a done pulse
//               o_active, o_src, o_dest, o_chunk, o_last, o_done
// Revision    : 1.0 - initial release
// ============================================================================
module video_dma_ctx
  import video_dma_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 64,
  parameter int unsigned LEN_WIDTH   = 16,   // at most 32
  parameter int unsigned CHUNK_BYTES = 512
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_enable,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [ADDR_WIDTH-1:0] i_src,
  input  logic [ADDR_WIDTH-1:0] i_dest,
  input  logic [LEN_WIDTH-1:0]  i_len,
  input  logic                  i_advance,
  input  logic                  i_discard,
  output logic                  o_active,
  output logic [ADDR_WIDTH-1:0] o_src,
  output logic [ADDR_WIDTH-1:0] o_dest,
  output logic [LEN_WIDTH-1:0]  o_chunk,
  output logic                  o_last,
  output logic                  o_done
);

  localparam logic [31:0] c_chunk_bytes = 32'(CHUNK_BYTES);

  logic                  r_active;
  logic [ADDR_WIDTH-1:0] r_src;
  logic [ADDR_WIDTH-1:0] r_dest;
  logic [LEN_WIDTH-1:0]  r_remaining;
  logic                  r_done;

  logic                  w_accept;
  logic [LEN_WIDTH-1:0]  w_len_aligned;
  logic [LEN_WIDTH-1:0]  w_chunk;
  logic                  w_last;

  assign o_req_ready   = i_enable & ~r_active;
  assign w_accept      = i_req_valid & o_req_ready;
  // Transfers are whole 8-byte beats; the low length bits are dropped.
  assign w_len_aligned = i_len & ~LEN_WIDTH'(7);
  assign w_chunk       = LEN_WIDTH'(min_u32(32'(r_remaining), c_chunk_bytes));
  assign w_last        = (r_remaining == w_chunk);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active    <= 1'b0;
      r_src       <= '0;
      r_dest      <= '0;
      r_remaining <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_discard) begin
        r_active <= 1'b0;
      end else if (i_advance) begin
        r_src       <= r_src + ADDR_WIDTH'(w_chunk);
        r_dest      <= r_dest + ADDR_WIDTH'(w_chunk);
        r_remaining <= r_remaining - w_chunk;
        if (w_last) begin
          r_active <= 1'b0;
          r_done   <= 1'b1;
        end
      end else if (w_accept) begin
        r_src       <= i_src;
        r_dest      <= i_dest;
        r_remaining <= w_len_aligned;
        // An empty request never occupies the mover; it just reports done.
        r_active    <= (w_len_aligned != '0);
        r_done      <= (w_len_aligned == '0);
      end
    end
  end

  assign o_active = r_active;
  assign o_src    = r_src;
  assign o_dest   = r_dest;
  assign o_chunk  = w_chunk;
  assign o_last   = w_last;
  assign o_done   = r_done;

endmodule
`default_nettype wire

// File: rtl/video_dma_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : video_dma_scheduler
// Description : Shares one data mover between the scanline prefetch port (L,
//               strict priority) and the auxiliary port (A). Requests are
//               split into chunks of at most CHUNK_BYTES; arbitration happens
//               only between chunks, so L preempts A at chunk boundaries and
//               A resumes from its saved context. Flags scanline underrun.
//               Optional statistics: define VIDEO_DMA_SCHED_STATS_EN.
// Ports       : aclk, aresetn (async, active low), enable_i
//               l_req_* / a_req_*, l_done_o / a_done_o : requester ports
//               l_deadline_i, underrun_o, underrun_clr_i : underrun flag
//               mover_*_o, mover_en_o, mover_done_i      : data mover
//               busy_o, stat_*_cnt_o                      : status
// Revision    : 1.0 - initial release
// ============================================================================
module video_dma_scheduler
  import video_dma_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 64,
  parameter int unsigned LEN_WIDTH   = 16,
  parameter int unsigned CHUNK_BYTES = 512
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  enable_i,
  input  logic                  l_req_valid_i,
  output logic                  l_req_ready_o,
  input  logic [ADDR_WIDTH-1:0] l_src_i,
  input  logic [ADDR_WIDTH-1:0] l_dest_i,
  input  logic [LEN_WIDTH-1:0]  l_len_i,
  output logic                  l_done_o,
  input  logic                  a_req_valid_i,
  output logic                  a_req_ready_o,
  input  logic [ADDR_WIDTH-1:0] a_src_i,
  input  logic [ADDR_WIDTH-1:0] a_dest_i,
  input  logic [LEN_WIDTH-1:0]  a_len_i,
  output logic                  a_done_o,
  input  logic                  l_deadline_i,
  output logic                  underrun_o,
  input  logic                  underrun_clr_i,
  output logic [ADDR_WIDTH-1:0] mover_src_addr_o,
  output logic [ADDR_WIDTH-1:0] mover_dest_addr_o,
  output logic [ADDR_WIDTH-1:0] mover_length_o,
  output logic                  mover_en_o,
  input  logic                  mover_done_i,
  output logic                  busy_o,
  output logic [31:0]           stat_l_cnt_o,
  output logic [31:0]           stat_a_cnt_o,
  output logic [31:0]           stat_urun_cnt_o
);

  sched_state_e r_state, w_state_nxt;
  req_id_e      r_sel, w_sel_nxt;
  dma_desc_t    r_desc, w_desc_nxt;
  logic         r_underrun;

  logic                  w_l_active, w_a_active;
  logic [ADDR_WIDTH-1:0] w_l_src, w_l_dest, w_a_src, w_a_dest;
  logic [LEN_WIDTH-1:0]  w_l_chunk, w_a_chunk;
  logic                  w_l_last;
  logic                  w_a_last_unused;
  logic                  w_chunk_done;
  logic                  w_l_adv, w_a_adv;
  logic                  w_discard;
  logic                  w_urun_set;

  assign w_chunk_done = (r_state == ISSUE) & mover_done_i;
  assign w_l_adv      = w_chunk_done & enable_i & (r_sel == REQ_L);
  assign w_a_adv      = w_chunk_done & enable_i & (r_sel == REQ_A);
  // While disabled, contexts are dropped as soon as no chunk is in flight
  // (including the edge where the in-flight chunk finishes).
  assign w_discard    = ~enable_i & ((r_state != ISSUE) | mover_done_i);

  video_dma_ctx #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .LEN_WIDTH  (LEN_WIDTH),
    .CHUNK_BYTES(CHUNK_BYTES)
  ) u_ctx_l (
    .clk        (aclk),
    .rst_n      (aresetn),
    .i_enable   (enable_i),
    .i_req_valid(l_req_valid_i),
    .o_req_ready(l_req_ready_o),
    .i_src      (l_src_i),
    .i_dest     (l_dest_i),
    .i_len      (l_len_i),
    .i_advance  (w_l_adv),
    .i_discard  (w_discard),
    .o_active   (w_l_active),
    .o_src      (w_l_src),
    .o_dest     (w_l_dest),
    .o_chunk    (w_l_chunk),
    .o_last     (w_l_last),
    .o_done     (l_done_o)
  );

  video_dma_ctx #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .LEN_WIDTH  (LEN_WIDTH),
    .CHUNK_BYTES(CHUNK_BYTES)
  ) u_ctx_a (
    .clk        (aclk),
    .rst_n      (aresetn),
    .i_enable   (enable_i),
    .i_req_valid(a_req_valid_i),
    .o_req_ready(a_req_ready_o),
    .i_src      (a_src_i),
    .i_dest     (a_dest_i),
    .i_len      (a_len_i),
    .i_advance  (w_a_adv),
    .i_discard  (w_discard),
    .o_active   (w_a_active),
    .o_src      (w_a_src),
    .o_dest     (w_a_dest),
    .o_chunk    (w_a_chunk),
    .o_last     (w_a_last_unused),
    .o_done     (a_done_o)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= IDLE;
      r_sel   <= REQ_L;
      r_desc  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_desc  <= w_desc_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_desc_nxt  = r_desc;
    case (r_state)
      IDLE: begin
        if (enable_i && (w_l_active || w_a_active)) begin
          if (w_l_active) begin
            w_sel_nxt       = REQ_L;
            w_desc_nxt.src  = MAX_ADDR_WIDTH'(w_l_src);
            w_desc_nxt.dest = MAX_ADDR_WIDTH'(w_l_dest);
            w_desc_nxt.len  = MAX_ADDR_WIDTH'(w_l_chunk);
          end else begin
            w_sel_nxt       = REQ_A;
            w_desc_nxt.src  = MAX_ADDR_WIDTH'(w_a_src);
            w_desc_nxt.dest = MAX_ADDR_WIDTH'(w_a_dest);
            w_desc_nxt.len  = MAX_ADDR_WIDTH'(w_a_chunk);
          end
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (mover_done_i) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        // Level handshake: the mover must drop done before the next chunk.
        if (!mover_done_i) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign mover_en_o        = (r_state == ISSUE);
  assign mover_src_addr_o  = r_desc.src[ADDR_WIDTH-1:0];
  assign mover_dest_addr_o = r_desc.dest[ADDR_WIDTH-1:0];
  assign mover_length_o    = r_desc.len[ADDR_WIDTH-1:0];
  assign busy_o            = (r_state != IDLE) | w_l_active | w_a_active;

  // A deadline on the very edge that finishes L's last chunk is on time.
  assign w_urun_set = l_deadline_i & w_l_active & ~(w_l_adv & w_l_last);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)             r_underrun <= 1'b0;
    else if (w_urun_set)      r_underrun <= 1'b1;
    else if (underrun_clr_i)  r_underrun <= 1'b0;
  end

  assign underrun_o = r_underrun;

`ifdef VIDEO_DMA_SCHED_STATS_EN
  logic [31:0] r_stat_l, r_stat_a, r_stat_urun;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_stat_l    <= '0;
      r_stat_a    <= '0;
      r_stat_urun <= '0;
    end else begin
      if (l_done_o)   r_stat_l    <= r_stat_l + 32'd1;
      if (a_done_o)   r_stat_a    <= r_stat_a + 32'd1;
      if (w_urun_set) r_stat_urun <= r_stat_urun + 32'd1;
    end
  end

  assign stat_l_cnt_o    = r_stat_l;
  assign stat_a_cnt_o    = r_stat_a;
  assign stat_urun_cnt_o = r_stat_urun;
`else
  assign stat_l_cnt_o    = '0;
  assign stat_a_cnt_o    = '0;
  assign stat_urun_cnt_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_video_dma_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_video_dma_scheduler
// Description : Self-checking bench for video_dma_scheduler with a responsive
//               data-mover model (random latency) and a chunk-list reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_video_dma_scheduler;

  localparam int AW = 64;
  localparam int LW = 16;
  localparam int CB = 512;
`ifdef VIDEO_DMA_SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct packed {
    logic [63:0] src;
    logic [63:0] dest;
    logic [63:0] len;
  } xfer_t;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          enable_i = 1'b0;
  logic          l_req_valid_i = 1'b0, a_req_valid_i = 1'b0;
  logic [AW-1:0] l_src_i = '0, l_dest_i = '0, a_src_i = '0, a_dest_i = '0;
  logic [LW-1:0] l_len_i = '0, a_len_i = '0;
  logic          l_deadline_i = 1'b0, underrun_clr_i = 1'b0;
  logic          mover_done_i = 1'b0;
  logic          l_req_ready_o, a_req_ready_o, l_done_o, a_done_o;
  logic          underrun_o, mover_en_o, busy_o;
  logic [AW-1:0] mover_src_addr_o, mover_dest_addr_o, mover_length_o;
  logic [31:0]   stat_l_cnt_o, stat_a_cnt_o, stat_urun_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 aclk = ~aclk;

  video_dma_scheduler #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW), .CHUNK_BYTES(CB)) dut (
    .aclk(aclk), .aresetn(aresetn), .enable_i(enable_i),
    .l_req_valid_i(l_req_valid_i), .l_req_ready_o(l_req_ready_o),
    .l_src_i(l_src_i), .l_dest_i(l_dest_i), .l_len_i(l_len_i), .l_done_o(l_done_o),
    .a_req_valid_i(a_req_valid_i), .a_req_ready_o(a_req_ready_o),
    .a_src_i(a_src_i), .a_dest_i(a_dest_i), .a_len_i(a_len_i), .a_done_o(a_done_o),
    .l_deadline_i(l_deadline_i), .underrun_o(underrun_o), .underrun_clr_i(underrun_clr_i),
    .mover_src_addr_o(mover_src_addr_o), .mover_dest_addr_o(mover_dest_addr_o),
    .mover_length_o(mover_length_o), .mover_en_o(mover_en_o), .mover_done_i(mover_done_i),
    .busy_o(busy_o), .stat_l_cnt_o(stat_l_cnt_o), .stat_a_cnt_o(stat_a_cnt_o),
    .stat_urun_cnt_o(stat_urun_cnt_o)
  );

  // Data mover model: raises done a random number of cycles after en, holds it
  // until en drops. Shares the scheduler reset.
  int mv_cnt = 0;
  int mv_lat = 1;
  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      mover_done_i <= 1'b0;
      mv_cnt       <= 0;
    end else if (mover_en_o && !mover_done_i) begin
      if (mv_cnt >= mv_lat) begin
        mover_done_i <= 1'b1;
        mv_cnt       <= 0;
        mv_lat       <= int'($urandom_range(0, 3));
      end else begin
        mv_cnt <= mv_cnt + 1;
      end
    end else if (!mover_en_o) begin
      mover_done_i <= 1'b0;
      mv_cnt       <= 0;
    end
  end

  // Monitor: one log entry per rising mover_en_o; counts done pulses.
  xfer_t log_q[$];
  int    l_done_seen = 0, a_done_seen = 0, desc_changes = 0;
  logic  prev_en = 1'b0;
  always @(negedge aclk) begin
    if (!aresetn) begin
      prev_en = 1'b0;
    end else begin
      xfer_t x;
      x.src  = mover_src_addr_o;
      x.dest = mover_dest_addr_o;
      x.len  = mover_length_o;
      if (l_done_o) l_done_seen++;
      if (a_done_o) a_done_seen++;
      if (mover_en_o && !prev_en) log_q.push_back(x);
      else if (mover_en_o && log_q.size() > 0 && log_q[$] !== x) desc_changes++;
      prev_en = mover_en_o;
    end
  end

  // Reference: every request is an ordered list of chunks.
  xfer_t exp_l_q[$], exp_a_q[$];
  int    exp_l_done = 0, exp_a_done = 0, exp_urun = 0;

  function automatic void add_expected(input bit is_l, input logic [63:0] src,
                                       input logic [63:0] dest, input int unsigned len);
    int unsigned rem;
    int unsigned c;
    xfer_t x;
    rem = len & ~32'd7;
    while (rem > 0) begin
      c = (rem > CB) ? CB : rem;
      x.src = src; x.dest = dest; x.len = 64'(c);
      if (is_l) exp_l_q.push_back(x); else exp_a_q.push_back(x);
      src += 64'(c); dest += 64'(c); rem -= c;
    end
  endfunction

  task automatic step();
    @(negedge aclk);
    #1;
  endtask

  task automatic send_req(input bit is_l, input logic [63:0] src, input logic [63:0] dest,
                          input int unsigned len);
    bit ok;
    ok = 1'b0;
    if (is_l) begin
      l_src_i = src; l_dest_i = dest; l_len_i = LW'(len); l_req_valid_i = 1'b1;
    end else begin
      a_src_i = src; a_dest_i = dest; a_len_i = LW'(len); a_req_valid_i = 1'b1;
    end
    for (int i = 0; i < 400; i++) begin
      if (is_l ? l_req_ready_o : a_req_ready_o) begin
        step();
        ok = 1'b1;
        break;
      end
      step();
    end
    if (is_l) l_req_valid_i = 1'b0; else a_req_valid_i = 1'b0;
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL accept_%s: handshake=%0d required=1", is_l ? "L" : "A", ok);
    end
  endtask

  task automatic wait_done(input bit is_l);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      if (is_l ? (l_done_seen >= exp_l_done) : (a_done_seen >= exp_a_done)) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL done_timeout_%s: done_seen=%0d required=%0d", is_l ? "L" : "A",
               is_l ? l_done_seen : a_done_seen, is_l ? exp_l_done : exp_a_done);
    end
  endtask

  task automatic test_reset();
    aresetn  = 1'b0;
    enable_i = 1'b0;
    repeat (3) step();
    n_checks++;
    if ({mover_en_o, busy_o, l_done_o, a_done_o, underrun_o, l_req_ready_o, a_req_ready_o} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b required 0000000",
               {mover_en_o, busy_o, l_done_o, a_done_o, underrun_o, l_req_ready_o, a_req_ready_o});
    end
    n_checks++;
    if ({mover_src_addr_o, mover_dest_addr_o, mover_length_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_desc: src=%0h dest=%0h len=%0h required 0",
               mover_src_addr_o, mover_dest_addr_o, mover_length_o);
    end
    n_checks++;
    if ({stat_l_cnt_o, stat_a_cnt_o, stat_urun_cnt_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_stats: l=%0d a=%0d u=%0d required 0", stat_l_cnt_o, stat_a_cnt_o, stat_urun_cnt_o);
    end
    enable_i = 1'b1;
    #1;
    n_checks++;
    if ({l_req_ready_o, a_req_ready_o} !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_ready_follows_enable: got %b required 11", {l_req_ready_o, a_req_ready_o});
    end
    step();
    aresetn = 1'b1;
    step();
  endtask

  task automatic test_single_l();
    log_q.delete(); exp_l_q.delete();
    add_expected(1'b1, 64'h1000, 64'h8000, 1280);
    send_req(1'b1, 64'h1000, 64'h8000, 1280);
    exp_l_done++;
    wait_done(1'b1);
    repeat (5) step();
    n_checks++;
    if (log_q.size() != 3) begin
      n_fail++;
      $display("FAIL single_chunk_count: got %0d required 3", log_q.size());
    end
    for (int i = 0; i < 3 && i < log_q.size(); i++) begin
      n_checks++;
      if (log_q[i] !== exp_l_q[i]) begin
        n_fail++;
        $display("FAIL single_chunk%0d: got src=%0h len=%0d required src=%0h len=%0d",
                 i, log_q[i].src, log_q[i].len, exp_l_q[i].src, exp_l_q[i].len);
      end
    end
    n_checks++;
    if (l_done_seen !== exp_l_done || desc_changes !== 0) begin
      n_fail++;
      $display("FAIL single_done_once: dones=%0d desc_changes=%0d required %0d/0",
               l_done_seen, desc_changes, exp_l_done);
    end
  endtask

  task automatic test_preempt();
    xfer_t order[$];
    bit    seen_en;
    log_q.delete(); exp_l_q.delete(); exp_a_q.delete();
    add_expected(1'b0, 64'h2000, 64'h9000, 2048);
    add_expected(1'b1, 64'h10000, 64'hA000, 256);
    order.push_back(exp_a_q[0]);
    order.push_back(exp_l_q[0]);
    for (int i = 1; i < 4; i++) order.push_back(exp_a_q[i]);
    send_req(1'b0, 64'h2000, 64'h9000, 2048);
    exp_a_done++;
    seen_en = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (mover_en_o) begin seen_en = 1'b1; break; end
      step();
    end
    n_checks++;
    if (!seen_en) begin
      n_fail++;
      $display("FAIL preempt_first_issue: mover_en_o=0 required 1");
    end
    send_req(1'b1, 64'h10000, 64'hA000, 256);
    exp_l_done++;
    wait_done(1'b1);
    wait_done(1'b0);
    repeat (5) step();
    n_checks++;
    if (log_q.size() != order.size()) begin
      n_fail++;
      $display("FAIL preempt_chunk_count: got %0d required %0d", log_q.size(), order.size());
    end
    for (int i = 0; i < order.size() && i < log_q.size(); i++) begin
      n_checks++;
      if (log_q[i] !== order[i]) begin
        n_fail++;
        $display("FAIL preempt_order%0d: got src=%0h len=%0d required src=%0h len=%0d",
                 i, log_q[i].src, log_q[i].len, order[i].src, order[i].len);
      end
    end
  endtask

  task automatic test_zero_len();
    int base;
    log_q.delete();
    base = l_done_seen;
    send_req(1'b1, 64'h3000, 64'h4000, 5);
    exp_l_done++;
    n_checks++;
    if (l_done_o !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_done_next_cycle: l_done_o=%b required 1", l_done_o);
    end
    step();
    n_checks++;
    if (l_done_o !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_done_one_cycle: l_done_o=%b required 0", l_done_o);
    end
    repeat (4) step();
    n_checks++;
    if (log_q.size() != 0 || mover_en_o !== 1'b0 || busy_o !== 1'b0 || l_done_seen != base + 1) begin
      n_fail++;
      $display("FAIL zero_no_mover: chunks=%0d en=%b busy=%b dones=%0d required 0/0/0/%0d",
               log_q.size(), mover_en_o, busy_o, l_done_seen - base, 1);
    end
  endtask

  task automatic test_underrun();
    bit ok;
    log_q.delete();
    send_req(1'b1, 64'h20000, 64'h30000, 4096);
    exp_l_done++;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (log_q.size() >= 2) begin ok = 1'b1; break; end
      step();
    end
    n_checks++;
    if (!ok || underrun_o !== 1'b0 || l_req_ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL urun_pre: reached=%0d underrun=%b l_ready=%b required 1/0/0", ok, underrun_o, l_req_ready_o);
    end
    l_deadline_i = 1'b1;
    step();
    l_deadline_i = 1'b0;
    exp_urun++;
    n_checks++;
    if (underrun_o !== 1'b1) begin
      n_fail++;
      $display("FAIL urun_set: underrun_o=%b required 1", underrun_o);
    end
    n_checks++;
    if (stat_urun_cnt_o !== (STATS ? 32'(exp_urun) : 32'd0)) begin
      n_fail++;
      $display("FAIL urun_stat1: got %0d required %0d", stat_urun_cnt_o, STATS ? exp_urun : 0);
    end
    l_deadline_i = 1'b1; underrun_clr_i = 1'b1;
    step();
    l_deadline_i = 1'b0; underrun_clr_i = 1'b0;
    exp_urun++;
    n_checks++;
    if (underrun_o !== 1'b1) begin
      n_fail++;
      $display("FAIL urun_set_beats_clr: underrun_o=%b required 1", underrun_o);
    end
    underrun_clr_i = 1'b1;
    step();
    underrun_clr_i = 1'b0;
    n_checks++;
    if (underrun_o !== 1'b0) begin
      n_fail++;
      $display("FAIL urun_clr: underrun_o=%b required 0", underrun_o);
    end
    wait_done(1'b1);
    step();
    l_deadline_i = 1'b1;
    step();
    l_deadline_i = 1'b0;
    n_checks++;
    if (underrun_o !== 1'b0 || stat_urun_cnt_o !== (STATS ? 32'(exp_urun) : 32'd0)) begin
      n_fail++;
      $display("FAIL urun_idle_deadline: underrun=%b stat=%0d required 0/%0d",
               underrun_o, stat_urun_cnt_o, STATS ? exp_urun : 0);
    end
  endtask

  task automatic test_disable();
    int  base_l, base_a;
    bit  ok;
    log_q.delete(); exp_l_q.delete();
    base_l = l_done_seen; base_a = a_done_seen;
    add_expected(1'b1, 64'h40000, 64'h50000, 2048);
    send_req(1'b1, 64'h40000, 64'h50000, 2048);
    send_req(1'b0, 64'h60000, 64'h70000, 1024);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (log_q.size() == 2 && mover_en_o) begin ok = 1'b1; break; end
      step();
    end
    enable_i = 1'b0;
    #1;
    n_checks++;
    if (!ok || {l_req_ready_o, a_req_ready_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL dis_start: in_chunk2=%0d ready=%b required 1/00", ok, {l_req_ready_o, a_req_ready_o});
    end
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (!busy_o) begin ok = 1'b1; break; end
    end
    repeat (8) step();
    n_checks++;
    if (!ok || busy_o !== 1'b0 || mover_en_o !== 1'b0) begin
      n_fail++;
      $display("FAIL dis_idle: busy_fell=%0d busy=%b en=%b required 1/0/0", ok, busy_o, mover_en_o);
    end
    n_checks++;
    if (log_q.size() != 2 || (log_q.size() == 2 && log_q[1] !== exp_l_q[1])) begin
      n_fail++;
      $display("FAIL dis_chunk2_only: chunks=%0d required 2", log_q.size());
    end
    n_checks++;
    if (l_done_seen != base_l || a_done_seen != base_a || {l_req_ready_o, a_req_ready_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL dis_no_done: l=%0d a=%0d ready=%b required 0/0/00",
               l_done_seen - base_l, a_done_seen - base_a, {l_req_ready_o, a_req_ready_o});
    end
    enable_i = 1'b1;
    step();
    repeat (5) step();
    n_checks++;
    if ({l_req_ready_o, a_req_ready_o} !== 2'b11 || log_q.size() != 2 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL dis_reenable: ready=%b chunks=%0d busy=%b required 11/2/0",
               {l_req_ready_o, a_req_ready_o}, log_q.size(), busy_o);
    end
  endtask

  task automatic test_random();
    xfer_t got_l[$], got_a[$];
    log_q.delete(); exp_l_q.delete(); exp_a_q.delete();
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          logic [63:0] s, d;
          int unsigned n;
          s = {32'h1, 32'($urandom) & 32'h0FFF_FFF8};
          d = {32'h3, 32'($urandom) & 32'h0FFF_FFF8};
          n = $urandom_range(0, 2600);
          add_expected(1'b1, s, d, n);
          send_req(1'b1, s, d, n);
          exp_l_done++;
          wait_done(1'b1);
        end
      end
      begin
        for (int j = 0; j < 6; j++) begin
          logic [63:0] s, d;
          int unsigned n;
          s = {32'h2, 32'($urandom) & 32'h0FFF_FFF8};
          d = {32'h4, 32'($urandom) & 32'h0FFF_FFF8};
          n = $urandom_range(0, 2600);
          add_expected(1'b0, s, d, n);
          send_req(1'b0, s, d, n);
          exp_a_done++;
          wait_done(1'b0);
        end
      end
    join
    repeat (5) step();
    foreach (log_q[k]) begin
      if (log_q[k].src[35:32] == 4'h1) got_l.push_back(log_q[k]);
      else got_a.push_back(log_q[k]);
    end
    n_checks++;
    if (got_l.size() != exp_l_q.size() || got_a.size() != exp_a_q.size()) begin
      n_fail++;
      $display("FAIL rand_chunk_counts: L=%0d A=%0d required L=%0d A=%0d",
               got_l.size(), got_a.size(), exp_l_q.size(), exp_a_q.size());
    end
    for (int i = 0; i < got_l.size() && i < exp_l_q.size(); i++) begin
      n_checks++;
      if (got_l[i] !== exp_l_q[i]) begin
        n_fail++;
        $display("FAIL rand_L%0d: got src=%0h len=%0d required src=%0h len=%0d",
                 i, got_l[i].src, got_l[i].len, exp_l_q[i].src, exp_l_q[i].len);
      end
    end
    for (int i = 0; i < got_a.size() && i < exp_a_q.size(); i++) begin
      n_checks++;
      if (got_a[i] !== exp_a_q[i]) begin
        n_fail++;
        $display("FAIL rand_A%0d: got src=%0h len=%0d required src=%0h len=%0d",
                 i, got_a[i].src, got_a[i].len, exp_a_q[i].src, exp_a_q[i].len);
      end
    end
    n_checks++;
    if (l_done_seen != exp_l_done || a_done_seen != exp_a_done || desc_changes != 0) begin
      n_fail++;
      $display("FAIL rand_dones: l=%0d a=%0d chg=%0d required %0d/%0d/0",
               l_done_seen, a_done_seen, desc_changes, exp_l_done, exp_a_done);
    end
    n_checks++;
    if (stat_l_cnt_o !== (STATS ? 32'(exp_l_done) : 32'd0) ||
        stat_a_cnt_o !== (STATS ? 32'(exp_a_done) : 32'd0)) begin
      n_fail++;
      $display("FAIL rand_stats: l=%0d a=%0d required %0d/%0d", stat_l_cnt_o, stat_a_cnt_o,
               STATS ? exp_l_done : 0, STATS ? exp_a_done : 0);
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    send_req(1'b1, 64'h80000, 64'h90000, 2048);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (mover_en_o) begin ok = 1'b1; break; end
      step();
    end
    #1;
    aresetn = 1'b0;
    #1;
    n_checks++;
    if (!ok || {mover_en_o, l_done_o, a_done_o, busy_o, underrun_o} !== 5'b0) begin
      n_fail++;
      $display("FAIL areset_flags: issued=%0d en/ld/ad/busy/urun=%b required 1/00000",
               ok, {mover_en_o, l_done_o, a_done_o, busy_o, underrun_o});
    end
    n_checks++;
    if ({stat_l_cnt_o, stat_a_cnt_o, stat_urun_cnt_o} !== '0 || mover_length_o !== '0) begin
      n_fail++;
      $display("FAIL areset_stats: l=%0d a=%0d u=%0d len=%0d required 0",
               stat_l_cnt_o, stat_a_cnt_o, stat_urun_cnt_o, mover_length_o);
    end
    n_checks++;
    if ({l_req_ready_o, a_req_ready_o} !== 2'b11) begin
      n_fail++;
      $display("FAIL areset_ready: got %b required 11", {l_req_ready_o, a_req_ready_o});
    end
    step();
    aresetn = 1'b1;
    repeat (3) step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_l();
    test_preempt();
    test_zero_len();
    test_underrun();
    test_random();
    test_disable();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
